// File: rtl/vga_scan_controller.sv
// -----------------------------------------------------------------------------
// vga_scan_controller
//
// Scan-out side of the renderer pixel interface. Generates 640x480@60 VGA
// timing on the pixel clock. It issues each pixel's linear address
// PIXEL_LATENCY+1 clocks before that pixel reaches the DAC outputs. It
// captures the colour the renderer returns, and it drives colour, syncs and
// blank with all of them aligned to the same pixel.
//
// Ports:
//   iClock       pixel clock
//   iReset       asynchronous reset, active-high
//   oAddress     linear pixel address y*H_ACTIVE+x (registered)
//   iPixel       {R,G,B}; must be valid PIXEL_LATENCY clocks after its address
//   oRed/oGreen/oBlue  DAC colour, forced to 0 while blanked
//   oHSync/oVSync      active-low syncs
//   oBlank       high outside the visible area
//   oFrameStart  one-clock pulse while pixel (0,0) is on the outputs
// -----------------------------------------------------------------------------
module vga_scan_controller #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int PIXEL_LATENCY = 3
) (
    input  logic        iClock,
    input  logic        iReset,
    output logic [18:0] oAddress,
    input  logic [23:0] iPixel,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oBlank,
    output logic        oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_ACT_W    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_W   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_FIRST_W = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST_W  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_ACT_W    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_W   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_FIRST_W = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST_W  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    localparam logic [18:0] LINE_W    = 19'(H_ACTIVE);
    localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    // Control word layout: {frame_start, vsync_n, hsync_n, blank}.
    // The idle value is what the outputs show while blanked.
    localparam logic [3:0] CTL_IDLE = 4'b0111;

    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic [18:0] r_address;
    logic [3:0]  r_ctl [0:PIXEL_LATENCY];
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic        r_frame_start;

    logic        w_fetch_active;
    logic [18:0] w_fetch_addr;
    logic [3:0]  w_ctl_raw;
    logic [3:0]  w_ctl_dly;

    // Fetch position counters: h runs every clock, v steps on h wrap.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST_W) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST_W) ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign w_fetch_active = (r_h < H_ACT_W) && (r_v < V_ACT_W);
    assign w_fetch_addr   = 19'(r_v) * LINE_W + 19'(r_h);

    // Outside the visible area the address simply holds, so the renderer sees
    // the row-end address in hblank and the last pixel in vblank. Address 0
    // therefore occurs exactly once per frame.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_address <= ADDR_LAST;
        end else if (w_fetch_active) begin
            r_address <= w_fetch_addr;
        end
    end

    assign w_ctl_raw = {
        (r_h == 10'd0) && (r_v == 10'd0),
        !((r_v >= VS_FIRST_W) && (r_v <= VS_LAST_W)),
        !((r_h >= HS_FIRST_W) && (r_h <= HS_LAST_W)),
        !w_fetch_active
    };

    // PIXEL_LATENCY+1 stages: one matches the address register, the rest
    // match the renderer's round trip, so the last stage lines up with iPixel.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i <= PIXEL_LATENCY; i++) begin
                r_ctl[i] <= CTL_IDLE;
            end
        end else begin
            r_ctl[0] <= w_ctl_raw;
            for (int i = 1; i <= PIXEL_LATENCY; i++) begin
                r_ctl[i] <= r_ctl[i-1];
            end
        end
    end

    assign w_ctl_dly = r_ctl[PIXEL_LATENCY];

    // Colour is masked with the delayed blank so that whatever the renderer
    // returns for blanking addresses never reaches the DAC.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_red         <= w_ctl_dly[0] ? 8'h00 : iPixel[23:16];
            r_green       <= w_ctl_dly[0] ? 8'h00 : iPixel[15:8];
            r_blue        <= w_ctl_dly[0] ? 8'h00 : iPixel[7:0];
            r_blank       <= w_ctl_dly[0];
            r_hsync       <= w_ctl_dly[1];
            r_vsync       <= w_ctl_dly[2];
            r_frame_start <= w_ctl_dly[3];
        end
    end

    assign oAddress    = r_address;
    assign oRed        = r_red;
    assign oGreen      = r_green;
    assign oBlue       = r_blue;
    assign oHSync      = r_hsync;
    assign oVSync      = r_vsync;
    assign oBlank      = r_blank;
    assign oFrameStart = r_frame_start;

endmodule

// File: tb/tb_vga_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_controller
//
// Three instances share one clock:
//   0: full 640x480 timing, PIXEL_LATENCY=3; covers the first lines and an
//      asynchronous reset in mid-line at fetch (300,1).
//   1: reduced geometry (8x4 visible, 16x9 total), PIXEL_LATENCY=1.
//   2: the same reduced geometry, PIXEL_LATENCY=5.
// The reduced instances run three whole frames each, so vsync, the frame
// period and the active pixel count per frame are observed within a short run.
// Each instance has an echo renderer that returns {5'b0, oAddress} PIXEL_LATENCY
// clocks later. The driver pushes the expected address and output records into
// queues. The expectations come from closed-form scan-position arithmetic. A
// separate monitor pops and compares the queues on every falling edge.
// -----------------------------------------------------------------------------
module tb_vga_scan_controller;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
    } out_t;

    localparam out_t RESET_REC = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank: 1'b1, fs: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h", name, inst, act, req);
        end
    endtask

    // Address on oAddress after fetch edge n: it tracks the beam while the
    // beam is visible, the row end during hblank, and the last pixel during vblank.
    function automatic logic [18:0] exp_addr(input int n, input int ha, input int ht,
                                             input int va, input int vt);
        int h;
        int v;
        h = n % ht;
        v = (n / ht) % vt;
        if (v >= va) return 19'(ha * va - 1);
        if (h >= ha) return 19'(v * ha + ha - 1);
        return 19'(v * ha + h);
    endfunction

    // Output record for the pixel fetched at edge n, with an echo renderer.
    function automatic out_t exp_out(input int n, input int ha, input int hf, input int hsw,
                                     input int ht, input int va, input int vf, input int vsw,
                                     input int vt);
        int   h;
        int   v;
        out_t r;
        h       = n % ht;
        v       = (n / ht) % vt;
        r.blank = !((h < ha) && (v < va));
        r.hs    = !((h >= ha + hf) && (h < ha + hf + hsw));
        r.vs    = !((v >= va + vf) && (v < va + vf + vsw));
        r.fs    = (h == 0) && (v == 0);
        r.rgb   = r.blank ? 24'h0 : 24'(v * ha + h);
        return r;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int HA   = (gi == 0) ? 640 : 8;
        localparam int HF   = (gi == 0) ? 16  : 2;
        localparam int HSW  = (gi == 0) ? 96  : 3;
        localparam int HB   = (gi == 0) ? 48  : 3;
        localparam int VA   = (gi == 0) ? 480 : 4;
        localparam int VF   = (gi == 0) ? 10  : 1;
        localparam int VSW  = 2;
        localparam int VB   = (gi == 0) ? 33  : 2;
        localparam int LAT  = (gi == 0) ? 3 : ((gi == 1) ? 1 : 5);
        localparam int HT   = HA + HF + HSW + HB;
        localparam int VT   = VA + VF + VSW + VB;
        localparam int SEGS = (gi == 0) ? 2 : 1;
        localparam int RUN0 = (gi == 0) ? (HT + 300 + 1) : (3 * HT * VT + 20);
        localparam int RUN1 = 2000;

        logic        rst;
        logic [18:0] addr;
        logic [23:0] pix;
        logic [7:0]  red;
        logic [7:0]  green;
        logic [7:0]  blue;
        logic        hs_n;
        logic        vs_n;
        logic        blank_o;
        logic        fs_o;
        bit          mon_en;

        out_t        exp_q[$];
        logic [18:0] addr_q[$];

        vga_scan_controller #(
            .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
            .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
            .PIXEL_LATENCY(LAT)
        ) u_dut (
            .iClock(clk),
            .iReset(rst),
            .oAddress(addr),
            .iPixel(pix),
            .oRed(red),
            .oGreen(green),
            .oBlue(blue),
            .oHSync(hs_n),
            .oVSync(vs_n),
            .oBlank(blank_o),
            .oFrameStart(fs_o)
        );

        function automatic out_t actual();
            return '{rgb: {red, green, blue}, hs: hs_n, vs: vs_n, blank: blank_o, fs: fs_o};
        endfunction

        task automatic chk_reset(input string tag);
            check({tag, "_out"}, gi, 32'(actual()), 32'(RESET_REC));
            check({tag, "_addr"}, gi, 32'(addr), 32'(HA * VA - 1));
        endtask

        initial begin : drv
            logic [18:0] hist[$];
            int          run_len;
            rst    = 1'b1;
            pix    = 24'h0;
            mon_en = 1'b0;
            repeat (3) @(posedge clk);
            #1 chk_reset("reset");
            for (int seg = 0; seg < SEGS; seg++) begin
                run_len = (seg == 0) ? RUN0 : RUN1;
                exp_q.delete();
                addr_q.delete();
                hist.delete();
                addr_q.push_back(exp_addr(0, HA, HT, VA, VT));
                for (int k = 0; k <= LAT; k++) exp_q.push_back(RESET_REC);
                @(negedge clk);
                rst = 1'b0;
                for (int n = 0; n < run_len; n++) begin
                    @(posedge clk);
                    #1;
                    mon_en = 1'b1;
                    // Echo renderer: the value driven now is sampled at the
                    // next edge, LAT+1 edges after the address was issued.
                    hist.push_back(addr);
                    if (hist.size() > LAT + 1) void'(hist.pop_front());
                    pix = (hist.size() == LAT + 1) ? {5'b0, hist[0]} : 24'h0;
                    addr_q.push_back(exp_addr(n + 1, HA, HT, VA, VT));
                    exp_q.push_back(exp_out(n, HA, HF, HSW, HT, VA, VF, VSW, VT));
                end
                @(negedge clk);
                #1;
                mon_en = 1'b0;
                if (seg + 1 < SEGS) begin
                    // Mid-line reset between clock edges: outputs must clear at once.
                    rst = 1'b1;
                    #1 chk_reset("async_reset");
                    repeat (5) @(posedge clk);
                    #1 chk_reset("held_reset");
                end
            end
            done_count++;
        end

        initial begin : mon
            int          m;
            int          last_fs;
            int          act_cnt;
            bit          fs_seen;
            out_t        exp_rec;
            logic [18:0] exp_a;
            forever begin
                wait (mon_en);
                m       = 0;
                last_fs = 0;
                act_cnt = 0;
                fs_seen = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!mon_en) break;
                    if (exp_q.size() == 0 || addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL queue_underrun inst=%0d edge=%0d actual=empty required=entry",
                                 gi, m);
                    end else begin
                        exp_rec = exp_q.pop_front();
                        exp_a   = addr_q.pop_front();
                        check($sformatf("addr@%0d", m), gi, 32'(addr), 32'(exp_a));
                        check($sformatf("out@%0d", m), gi, 32'(actual()), 32'(exp_rec));
                    end
                    if (fs_o) begin
                        if (fs_seen) begin
                            check("frame_period", gi, 32'(m - last_fs), 32'(HT * VT));
                            check("active_count", gi, 32'(act_cnt), 32'(HA * VA));
                        end
                        fs_seen = 1'b1;
                        last_fs = m;
                        act_cnt = 0;
                    end
                    if (!blank_o) act_cnt++;
                    m++;
                end
            end
        end
    end

    initial begin : top
        int waited;
        waited = 0;
        while (done_count < 3 && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (done_count < 3) begin
            checks++;
            failures++;
            $display("FAIL timeout actual_done=%0d required_done=3", done_count);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
